// File: rtl/wavelet_sequencer_pkg.sv
// Shared definitions for the wavelet sequencer and the FIR bank it feeds:
// FSM state encodings, default geometry and the filter-index width helper.
package wavelet_sequencer_pkg;

    localparam logic [1:0] WS_IDLE = 2'd0;
    localparam logic [1:0] WS_CALC = 2'd1;
    localparam logic [1:0] WS_DONE = 2'd2;

    localparam int DEFAULT_BITS_PER_ELEM = 8;
    localparam int DEFAULT_NUM_ELEM      = 7;
    localparam int DEFAULT_NUM_FILTERS   = 4;

    // A single filter still needs a one-bit index port.
    function automatic int idx_bits(input int num_filters);
        return (num_filters > 1) ? $clog2(num_filters) : 1;
    endfunction

endpackage

// File: rtl/wavelet_sequencer_tap.sv
// Tap delay line: element 0 holds the newest sample, the oldest element
// falls off the end on every enabled shift.
module tap_line
    import wavelet_sequencer_pkg::*;
#(
    parameter int BITS_PER_ELEM = DEFAULT_BITS_PER_ELEM,
    parameter int NUM_ELEM      = DEFAULT_NUM_ELEM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              shift_en,
    input  logic [BITS_PER_ELEM-1:0]          sample,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps
);

    // NOTE: the line is a handful of flops, not a RAM, so it is reset to
    // zero and the filters see a clean history after every reset.
    generate
        if (NUM_ELEM == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    taps <= '0;
                end else if (shift_en) begin
                    taps <= sample;
                end
            end
        end else begin : g_multi
            // NOTE: non-blocking so every element reads its neighbour's old value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    taps <= '0;
                end else if (shift_en) begin
                    taps <= {taps[(NUM_ELEM-1)*BITS_PER_ELEM-1:0], sample};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wavelet_sequencer.sv
// Sequencer for the wavelet FIR bank: captures a sample into the tap line,
// fires each filter's start strobe one per cycle, then pulses done.
module wavelet_sequencer
    import wavelet_sequencer_pkg::*;
#(
    parameter int BITS_PER_ELEM = DEFAULT_BITS_PER_ELEM,
    parameter int NUM_ELEM      = DEFAULT_NUM_ELEM,
    parameter int NUM_FILTERS   = DEFAULT_NUM_FILTERS,
    parameter int IDX_BITS      = idx_bits(NUM_FILTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_sample_valid,
    input  logic [BITS_PER_ELEM-1:0]          i_sample,
    input  logic                              i_clear_overrun,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
    output logic [NUM_FILTERS-1:0]            o_start_calc,
    output logic [IDX_BITS-1:0]               o_filter_idx,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overrun
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_FILTERS - 1);

    logic [1:0]               state;
    logic [IDX_BITS-1:0]      k;
    logic                     pending_valid;
    logic [BITS_PER_ELEM-1:0] pending_sample;
    logic                     shift_en;
    logic [BITS_PER_ELEM-1:0] shift_data;
    logic                     drop;

    // A sample arriving in DONE with nothing pending goes straight into the
    // line, so pending can never be left occupied when the FSM reaches IDLE.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        shift_en   = 1'b0;
        shift_data = i_sample;
        drop       = 1'b0;
        case (state)
            WS_IDLE: shift_en = i_sample_valid;
            WS_CALC: drop = i_sample_valid && pending_valid;
            WS_DONE: begin
                shift_en = pending_valid || i_sample_valid;
                if (pending_valid) begin
                    shift_data = pending_sample;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WS_IDLE;
            k     <= '0;
        end else begin
            case (state)
                WS_IDLE: begin
                    k <= '0;
                    if (i_sample_valid) begin
                        state <= WS_CALC;
                    end
                end
                WS_CALC: begin
                    if (k == LAST_IDX) begin
                        state <= WS_DONE;
                        k     <= '0;
                    end else begin
                        k <= k + IDX_BITS'(1);
                    end
                end
                WS_DONE: begin
                    k     <= '0;
                    state <= shift_en ? WS_CALC : WS_IDLE;
                end
                default: begin
                    state <= WS_IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

    // In DONE the pending slot is emptied into the line on the same edge,
    // so a simultaneous new sample can take its place without overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_valid  <= 1'b0;
            pending_sample <= '0;
        end else begin
            case (state)
                WS_CALC: begin
                    if (i_sample_valid && !pending_valid) begin
                        pending_valid  <= 1'b1;
                        pending_sample <= i_sample;
                    end
                end
                WS_DONE: begin
                    if (pending_valid) begin
                        pending_valid <= i_sample_valid;
                        if (i_sample_valid) begin
                            pending_sample <= i_sample;
                        end
                    end
                end
                default: pending_valid <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_overrun <= 1'b0;
        end else if (drop) begin
            o_overrun <= 1'b1;
        end else if (i_clear_overrun) begin
            o_overrun <= 1'b0;
        end
    end

    always_comb begin
        o_start_calc = '0;
        if (state == WS_CALC) begin
            o_start_calc[k] = 1'b1;
        end
    end

    assign o_filter_idx = k;
    assign o_busy       = (state != WS_IDLE);
    assign o_done       = (state == WS_DONE);

    tap_line #(
        .BITS_PER_ELEM(BITS_PER_ELEM),
        .NUM_ELEM     (NUM_ELEM)
    ) u_tap_line (
        .clk     (clk),
        .rst     (rst),
        .shift_en(shift_en),
        .sample  (shift_data),
        .taps    (o_taps)
    );

endmodule

// File: tb/tb_wavelet_sequencer.sv
// Scoreboard bench for wavelet_sequencer: directed samples push expected
// start strobes and done-time taps; a negedge monitor pops and compares.
module tb_wavelet_sequencer;

    localparam int BPE = 8;
    localparam int NE  = 7;
    localparam int NF  = 4;
    localparam int IB  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_sample_valid;
    logic [BPE-1:0]    i_sample;
    logic              i_clear_overrun;
    logic [NE*BPE-1:0] o_taps;
    logic [NF-1:0]     o_start_calc;
    logic [IB-1:0]     o_filter_idx;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun;

    typedef struct packed {
        logic [NF-1:0] start;
        logic [IB-1:0] idx;
    } start_t;

    start_t            start_q[$];
    logic [NE*BPE-1:0] done_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wavelet_sequencer #(
        .BITS_PER_ELEM(BPE),
        .NUM_ELEM     (NE),
        .NUM_FILTERS  (NF),
        .IDX_BITS     (IB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_clear_overrun(i_clear_overrun),
        .o_taps         (o_taps),
        .o_start_calc   (o_start_calc),
        .o_filter_idx   (o_filter_idx),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overrun      (o_overrun)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [BPE-1:0] s);
        i_sample       = s;
        i_sample_valid = 1'b1;
        @(posedge clk);
        #1;
        i_sample_valid = 1'b0;
    endtask

    task automatic push_seq(input logic [NE*BPE-1:0] taps);
        start_t e;
        for (int k = 0; k < NF; k++) begin
            e.start = NF'(1) << k;
            e.idx   = IB'(k);
            start_q.push_back(e);
        end
        done_q.push_back(taps);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 64'(o_start_calc), 64'd0);
        check({tag, "_idx"},   64'(o_filter_idx), 64'd0);
        check({tag, "_busy"},  64'(o_busy),       64'd0);
        check({tag, "_done"},  64'(o_done),       64'd0);
        check({tag, "_ovr"},   64'(o_overrun),    64'd0);
        check({tag, "_taps"},  64'(o_taps),       64'd0);
    endtask

    task automatic do_reset();
        i_sample_valid  = 1'b0;
        i_sample        = '0;
        i_clear_overrun = 1'b0;
        rst             = 1'b1;
        #1;
        start_q.delete();
        done_q.delete();
        check_all_zero("reset");
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
    endtask

    // Monitor: compare every start strobe and every done pulse against the queues.
    initial begin
        start_t e;
        logic [NE*BPE-1:0] t;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (o_start_calc != '0) begin
                    if (start_q.size() == 0) begin
                        check("unexpected_start", 64'(o_start_calc), 64'd0);
                    end else begin
                        e = start_q.pop_front();
                        check("start_calc", 64'(o_start_calc), 64'(e.start));
                        check("filter_idx", 64'(o_filter_idx), 64'(e.idx));
                    end
                end
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 64'(o_done), 64'd0);
                    end else begin
                        t = done_q.pop_front();
                        check("done_taps", 64'(o_taps), 64'(t));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NE*BPE-1:0] exp_seven[7];
        exp_seven = '{56'h01, 56'h0102, 56'h010203, 56'h01020304,
                      56'h0102030405, 56'h010203040506, 56'h01020304050607};

        // Single sample: strobes in cycles 1-4, done in cycle 5.
        do_reset();
        strobe(8'h05);
        push_seq(56'h05);
        check("t1_start_c1", 64'(o_start_calc), 64'h1);
        check("t1_taps_c1",  64'(o_taps),       64'h05);
        wait_cycles(3);
        check("t1_start_c4", 64'(o_start_calc), 64'h8);
        check("t1_idx_c4",   64'(o_filter_idx), 64'd3);
        check("t1_done_c4",  64'(o_done),       64'd0);
        wait_cycles(1);
        check("t1_done_c5",  64'(o_done),       64'd1);
        check("t1_busy_c5",  64'(o_busy),       64'd1);
        check("t1_start_c5", 64'(o_start_calc), 64'd0);
        wait_cycles(1);
        check("t1_busy_c6",  64'(o_busy),       64'd0);
        check("t1_done_c6",  64'(o_done),       64'd0);

        // Seven samples at full throughput, one every five cycles.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            strobe(BPE'(i + 1));
            push_seq(exp_seven[i]);
            wait_cycles(4);
        end
        check("t2_done",  64'(o_done),    64'd1);
        check("t2_taps",  64'(o_taps),    64'h01020304050607);
        check("t2_ovr",   64'(o_overrun), 64'd0);
        wait_cycles(1);

        // A, then B pending, then C dropped with overrun.
        do_reset();
        strobe(8'h0A);
        push_seq(56'h0A);
        wait_cycles(1);
        strobe(8'h0B);
        push_seq(56'h0A0B);
        strobe(8'h0C);
        check("t3_ovr_set",     64'(o_overrun), 64'd1);
        check("t3_taps_stable", 64'(o_taps),    64'h0A);
        wait_cycles(6);
        check("t3_done_b",      64'(o_done),    64'd1);
        check("t3_taps_b",      64'(o_taps),    64'h0A0B);
        wait_cycles(1);
        check("t3_idle",        64'(o_busy),    64'd0);
        check("t3_ovr_held",    64'(o_overrun), 64'd1);
        i_clear_overrun = 1'b1;
        wait_cycles(1);
        i_clear_overrun = 1'b0;
        check("t3_ovr_clear",   64'(o_overrun), 64'd0);

        // New sample lands in DONE while B is pending: no overrun, three dones.
        do_reset();
        strobe(8'h11);
        push_seq(56'h11);
        strobe(8'h22);
        push_seq(56'h1122);
        wait_cycles(3);
        check("t4_done_a", 64'(o_done), 64'd1);
        strobe(8'h33);
        push_seq(56'h112233);
        check("t4_ovr",    64'(o_overrun), 64'd0);
        check("t4_taps_b", 64'(o_taps),    64'h1122);
        wait_cycles(4);
        check("t4_done_b", 64'(o_done),    64'd1);
        wait_cycles(5);
        check("t4_done_c", 64'(o_done),    64'd1);
        check("t4_taps_c", 64'(o_taps),    64'h112233);
        wait_cycles(1);
        check("t4_idle",   64'(o_busy),    64'd0);
        check("t4_ovr_end", 64'(o_overrun), 64'd0);

        // Reset in cycle 2 of CALC aborts with no done.
        do_reset();
        strobe(8'h44);
        push_seq(56'h44);
        wait_cycles(1);
        rst = 1'b1;
        #1;
        start_q.delete();
        done_q.delete();
        check_all_zero("abort");
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(10);
        check("abort_idle", 64'(o_busy), 64'd0);

        // Drop and clear in the same cycle: set wins.
        do_reset();
        strobe(8'h55);
        push_seq(56'h55);
        strobe(8'h66);
        push_seq(56'h5566);
        i_clear_overrun = 1'b1;
        strobe(8'h77);
        i_clear_overrun = 1'b0;
        check("t6_ovr_priority", 64'(o_overrun), 64'd1);
        wait_cycles(8);
        check("t6_idle", 64'(o_busy), 64'd0);

        check("start_q_empty", 64'(start_q.size()), 64'd0);
        check("done_q_empty",  64'(done_q.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
